// File: rtl/sensor_pkg.sv
// Shared HC-SR04 definitions used by the echo responder, the sensor
// controller and the clock divider: FSM state encodings, 50 MHz timing
// constants and a small helper for sizing counters.
package sensor_pkg;

    // Timing at a 50 MHz board clock
    localparam int CLK_HZ            = 50_000_000;
    localparam int TRIG_MIN_CYC_50M  = 500;        // 10 us trigger
    localparam int CYC_PER_CM_50M    = 2900;       // 58 us per cm
    localparam int TIMEOUT_CYC_50M   = 1_900_000;  // 38 ms no-echo width
    localparam int BURST_CYC_50M     = 10_000;     // 200 us emulated burst
    localparam int HOLDOFF_CYC_50M   = 500_000;    // 10 ms dead time
    localparam int MAX_CM_DEF        = 200;

    // Responder FSM state encodings
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TRIG_HIGH = 3'd1;
    localparam logic [2:0] BURST     = 3'd2;
    localparam logic [2:0] ECHO      = 3'd3;
    localparam logic [2:0] HOLDOFF   = 3'd4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hcsr04_echo_responder_if.sv
// Trigger/echo link between the sensor controller (master) and the
// sensor or its emulator (slave).
//   Trigger        : controller -> sensor, start a measurement
//   Distance_Cm    : emulated distance (emulator only)
//   Object_Present : 0 forces a timeout-width echo (emulator only)
//   Echo           : sensor -> controller, width encodes distance
//   Busy           : emulator is not idle
//   Trig_Short     : one-cycle pulse, trigger rejected as too short
interface hcsr04_if;
    logic       Trigger;
    logic [7:0] Distance_Cm;
    logic       Object_Present;
    logic       Echo;
    logic       Busy;
    logic       Trig_Short;

    modport master (
        output Trigger, Distance_Cm, Object_Present,
        input  Echo, Busy, Trig_Short
    );

    modport slave (
        input  Trigger, Distance_Cm, Object_Present,
        output Echo, Busy, Trig_Short
    );
endinterface

// File: rtl/hcsr04_echo_responder_sync.sv
// sync_2ff: generic two-flop synchroniser for signals asynchronous to clk.
//   clk, rst : clock, synchronous active-high reset (clears both stages)
//   d        : asynchronous input
//   q        : synchronised output, two cycles behind d
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/hcsr04_echo_responder.sv
// HC-SR04 responder emulator. Accepts a trigger of sufficient width, waits
// an emulated burst time, then drives Echo for a width proportional to the
// programmed distance, followed by a dead time where triggers are ignored.
//   CLK, RST : board clock, synchronous active-high reset
//   sen      : slave side of the trigger/echo link (see hcsr04_if)
module hcsr04_echo_responder
    import sensor_pkg::*;
#(
    parameter int TRIG_MIN_CYC = TRIG_MIN_CYC_50M,
    parameter int BURST_CYC    = BURST_CYC_50M,
    parameter int CYC_PER_CM   = CYC_PER_CM_50M,
    parameter int TIMEOUT_CYC  = TIMEOUT_CYC_50M,
    parameter int HOLDOFF_CYC  = HOLDOFF_CYC_50M,
    parameter int MAX_CM       = MAX_CM_DEF
) (
    input logic   CLK,
    input logic   RST,
    hcsr04_if.slave sen
);
    localparam int ECHO_MAX = max2(TIMEOUT_CYC, MAX_CM * CYC_PER_CM);
    localparam int ECHO_W   = $clog2(ECHO_MAX + 1);
    localparam int CNT_W    = $clog2(max2(ECHO_MAX, max2(BURST_CYC, HOLDOFF_CYC)) + 1);
    localparam int HI_W     = $clog2(TRIG_MIN_CYC + 1);

    logic              ts, ts_d, rise, fall;
    logic [2:0]        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [HI_W-1:0]   hi_cnt, hi_n;
    logic [ECHO_W-1:0] echo_len, len_n, len_calc;
    logic              short_n;
    logic              echo_r, busy_r, short_r;

    sync_2ff #(.W(1)) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (sen.Trigger),
        .q   (ts)
    );

    assign rise = ts & ~ts_d;
    assign fall = ~ts & ts_d;

    // Echo width from the live inputs; only sampled into echo_len on the
    // accepted trigger fall, so later input changes cannot affect it.
    always_comb begin
        len_calc = '0;
        if (!sen.Object_Present || int'(sen.Distance_Cm) > MAX_CM)
            len_calc = ECHO_W'(TIMEOUT_CYC);
        else if (sen.Distance_Cm == 8'd0)
            len_calc = ECHO_W'(CYC_PER_CM);
        else
            len_calc = ECHO_W'(sen.Distance_Cm) * ECHO_W'(CYC_PER_CM);
    end

    // One down-counter serves BURST, ECHO and HOLDOFF; it is loaded with
    // (length - 1) on entry so each state lasts exactly 'length' cycles.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hi_n    = hi_cnt;
        len_n   = echo_len;
        short_n = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = TRIG_HIGH;
                    hi_n    = HI_W'(1);
                end
            end
            TRIG_HIGH: begin
                if (fall) begin
                    if (hi_cnt >= HI_W'(TRIG_MIN_CYC)) begin
                        state_n = BURST;
                        cnt_n   = CNT_W'(BURST_CYC - 1);
                        len_n   = len_calc;
                    end else begin
                        state_n = IDLE;
                        short_n = 1'b1;
                    end
                end else if (ts && hi_cnt != HI_W'(TRIG_MIN_CYC)) begin
                    hi_n = hi_cnt + HI_W'(1);
                end
            end
            BURST: begin
                if (cnt == '0) begin
                    state_n = ECHO;
                    cnt_n   = CNT_W'(echo_len) - CNT_W'(1);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ECHO: begin
                if (cnt == '0) begin
                    state_n = HOLDOFF;
                    cnt_n   = CNT_W'(HOLDOFF_CYC - 1);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            HOLDOFF: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - CNT_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the state and are glitch-free.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ts_d     <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            hi_cnt   <= '0;
            echo_len <= '0;
            echo_r   <= 1'b0;
            busy_r   <= 1'b0;
            short_r  <= 1'b0;
        end else begin
            ts_d     <= ts;
            state    <= state_n;
            cnt      <= cnt_n;
            hi_cnt   <= hi_n;
            echo_len <= len_n;
            echo_r   <= (state_n == ECHO);
            busy_r   <= (state_n != IDLE);
            short_r  <= short_n;
        end
    end

    assign sen.Echo       = echo_r;
    assign sen.Busy       = busy_r;
    assign sen.Trig_Short = short_r;
endmodule

// File: tb/tb_hcsr04_echo_responder.sv
module tb_hcsr04_echo_responder;
    localparam int TRIG_MIN = 4;
    localparam int BURST    = 8;
    localparam int CPC      = 3;
    localparam int TMO      = 100;
    localparam int HOLD     = 20;
    localparam int MAXCM    = 20;
    localparam int LIM      = 2000;

    localparam int K_ECHO  = 0;
    localparam int K_SHORT = 1;

    typedef struct {
        int kind;
        int width;
        int rise;
        int hold;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    hcsr04_if sen();

    hcsr04_echo_responder #(
        .TRIG_MIN_CYC (TRIG_MIN),
        .BURST_CYC    (BURST),
        .CYC_PER_CM   (CPC),
        .TIMEOUT_CYC  (TMO),
        .HOLDOFF_CYC  (HOLD),
        .MAX_CM       (MAXCM)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .sen (sen)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string nm, input int n);
        tests++;
        if (n >= LIM) begin
            fails++;
            $display("FAIL %s: waited %0d cycles, limit %0d", nm, n, LIM);
        end
    endtask

    // Raw Trigger high for n cycles; echo rise is expected BURST+3 edges
    // after the drop (2 sync + 1 fall detect, then BURST cycles).
    task automatic pulse(input int n, input bit exp_echo, input int w, input int hold);
        @(posedge CLK); #1;
        sen.Trigger = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
        sen.Trigger = 1'b0;
        if (exp_echo) q.push_back(exp_t'{K_ECHO, w, cyc + BURST + 3, hold});
    endtask

    task automatic wait_echo(input bit lvl, input string nm);
        int n = 0;
        while (sen.Echo !== lvl && n < LIM) begin
            @(negedge CLK);
            n++;
        end
        bound_fail(nm, n);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        repeat (6) @(negedge CLK);
        while ((sen.Busy !== 1'b0 || sen.Echo !== 1'b0) && n < LIM) begin
            @(negedge CLK);
            n++;
        end
        bound_fail(nm, n);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an echo pulse
    // or a Trig_Short pulse, and checks rise time, width and dead time.
    initial begin
        bit   e_prev = 0, b_prev = 0, s_prev = 0, pend = 0;
        int   ew = 0, sw = 0, fcyc = 0, hold = 0;
        exp_t it;
        forever begin
            @(negedge CLK);
            if (sen.Echo === 1'b1 && !e_prev) begin
                ew = 0;
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL echo_unexpected: echo rose at cycle %0d with nothing expected", cyc);
                end else begin
                    check("echo_kind", q[0].kind, K_ECHO);
                    check("echo_rise_cycle", cyc, q[0].rise);
                end
            end
            if (sen.Echo === 1'b1) ew++;
            if (sen.Echo === 1'b0 && e_prev) begin
                if (q.size() > 0) begin
                    it = q.pop_front();
                    check("echo_width", ew, it.width);
                    pend = 1; hold = it.hold; fcyc = cyc;
                end
            end
            if (sen.Busy === 1'b0 && b_prev && pend) begin
                check("busy_after_echo", cyc - fcyc, hold);
                pend = 0;
            end
            if (sen.Trig_Short === 1'b1 && !s_prev) begin
                sw = 0;
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL short_unexpected: Trig_Short at cycle %0d with nothing expected", cyc);
                end else begin
                    it = q.pop_front();
                    check("short_kind", it.kind, K_SHORT);
                end
            end
            if (sen.Trig_Short === 1'b1) sw++;
            if (sen.Trig_Short === 1'b0 && s_prev) check("short_width", sw, 1);
            e_prev = (sen.Echo === 1'b1);
            b_prev = (sen.Busy === 1'b1);
            s_prev = (sen.Trig_Short === 1'b1);
        end
    end

    initial begin
        sen.Trigger        = 1'b0;
        sen.Distance_Cm    = 8'd5;
        sen.Object_Present = 1'b1;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_echo",  int'(sen.Echo),       0);
        check("rst_busy",  int'(sen.Busy),       0);
        check("rst_short", int'(sen.Trig_Short), 0);
        RST = 1'b0;

        // Nominal 5 cm
        pulse(6, 1, 15, HOLD);
        wait_idle("nominal_idle");

        // Short trigger
        q.push_back(exp_t'{K_SHORT, 1, 0, 0});
        pulse(2, 0, 0, 0);
        wait_idle("short_idle");
        repeat (3) @(negedge CLK);
        check("short_busy_low", int'(sen.Busy), 0);

        // Out of range, no object, zero distance
        sen.Distance_Cm = 8'd21;
        pulse(6, 1, TMO, HOLD);
        wait_idle("range_idle");
        sen.Distance_Cm = 8'd5; sen.Object_Present = 1'b0;
        pulse(6, 1, TMO, HOLD);
        wait_idle("noobj_idle");
        sen.Object_Present = 1'b1; sen.Distance_Cm = 8'd0;
        pulse(6, 1, CPC, HOLD);
        wait_idle("zero_idle");
        sen.Distance_Cm = 8'd20;
        pulse(6, 1, 60, HOLD);
        wait_idle("max_idle");
        sen.Distance_Cm = 8'd5;

        // Retriggers during ECHO and HOLDOFF are ignored
        pulse(6, 1, 15, HOLD);
        wait_echo(1, "retrig_echo_rise");
        pulse(3, 0, 0, 0);
        wait_echo(0, "retrig_echo_fall");
        pulse(6, 0, 0, 0);
        wait_idle("retrig_idle");

        // Distance change during BURST does not affect the pulse
        pulse(6, 1, 15, HOLD);
        repeat (3) @(posedge CLK);
        #1 sen.Distance_Cm = 8'd10;
        wait_idle("latch_idle");
        sen.Distance_Cm = 8'd5;

        // Reset five cycles into ECHO
        pulse(6, 1, 5, 0);
        wait_echo(1, "rst_echo_rise");
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_echo", int'(sen.Echo), 0);
        check("midrst_busy", int'(sen.Busy), 0);
        RST = 1'b0;
        pulse(6, 1, 15, HOLD);
        wait_idle("post_rst_idle");

        // Stuck-high trigger gives one echo
        pulse(50, 1, 15, HOLD);
        wait_idle("stuck_idle");

        // Trigger high across the end of HOLDOFF: no echo without a new rise
        pulse(6, 1, 15, HOLD);
        wait_echo(1, "hold_echo_rise");
        wait_echo(0, "hold_echo_fall");
        @(posedge CLK); #1 sen.Trigger = 1'b1;
        wait_idle("hold_idle");
        repeat (30) @(negedge CLK);
        check("held_busy", int'(sen.Busy), 0);
        check("held_echo", int'(sen.Echo), 0);
        sen.Trigger = 1'b0;
        repeat (5) @(negedge CLK);
        check("release_busy", int'(sen.Busy), 0);
        pulse(6, 1, 15, HOLD);
        wait_idle("final_idle");

        repeat (5) @(negedge CLK);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
